// File: rtl/decompression_serializer.sv
// Unpacks 32-bit memory words into a 16-bit DC stream followed by an MSB-first 12-bit code stream.
// Outputs are decoded from registered state; words are fetched only while the block still needs bits.
module decompression_serializer #(
  parameter int WIDTH      = 16,
  parameter int AHB_WIDTH  = 32,
  parameter int CODE_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            num_dc,
  input  logic [15:0]           num_codes,
  input  logic [AHB_WIDTH-1:0]  word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [WIDTH-1:0]      dc_out,
  output logic                  dc_valid,
  output logic [CODE_WIDTH-1:0] code_out,
  output logic                  code_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int BUF_W = 2 * AHB_WIDTH;
  localparam logic [5:0] DC_W   = 6'(WIDTH);
  localparam logic [5:0] CODE_W = 6'(CODE_WIDTH);
  localparam logic [5:0] WORD_W = 6'(AHB_WIDTH);

  typedef enum logic [1:0] {IDLE, DC, CODE} state_t;

  state_t           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [7:0]       dc_left_q, dc_left_d;
  logic [15:0]      code_left_q, code_left_d;
  logic             done_q, done_d;

  logic push, pop_dc, pop_code;

  assign word_ready = ((state_q == DC) && (cnt_q < DC_W)) ||
                      ((state_q == CODE) && (cnt_q < CODE_W));
  assign dc_valid   = (state_q == DC) && (cnt_q >= DC_W);
  assign code_valid = (state_q == CODE) && (cnt_q >= CODE_W);
  assign dc_out     = buf_q[BUF_W-1 -: WIDTH];
  assign code_out   = buf_q[BUF_W-1 -: CODE_WIDTH];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // word_ready and the valids are mutually exclusive on cnt, so push and pop never coincide
  assign push     = word_valid & word_ready;
  assign pop_dc   = dc_valid & out_ready;
  assign pop_code = code_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    dc_left_d   = dc_left_q;
    code_left_d = code_left_q;
    done_d      = 1'b0;
    if (push) begin
      buf_d = buf_q | ({word_in, {AHB_WIDTH{1'b0}}} >> cnt_q);
      cnt_d = cnt_q + WORD_W;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          dc_left_d   = num_dc;
          code_left_d = num_codes;
          if (num_dc != 8'd0)          state_d = DC;
          else if (num_codes != 16'd0) state_d = CODE;
          else                         done_d  = 1'b1;
        end
      end
      DC: begin
        if (pop_dc) begin
          dc_left_d = dc_left_q - 8'd1;
          // last DC: drop the padding half-word so codes start word-aligned
          if (dc_left_q == 8'd1) begin
            buf_d = '0;
            cnt_d = '0;
            if (code_left_q != 16'd0) state_d = CODE;
            else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            buf_d = buf_q << WIDTH;
            cnt_d = cnt_q - DC_W;
          end
        end
      end
      CODE: begin
        if (pop_code) begin
          code_left_d = code_left_q - 16'd1;
          if (code_left_q == 16'd1) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            buf_d = buf_q << CODE_WIDTH;
            cnt_d = cnt_q - CODE_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      dc_left_q   <= '0;
      code_left_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      dc_left_q   <= dc_left_d;
      code_left_q <= code_left_d;
      done_q      <= done_d;
    end
  end

endmodule
